// File: rtl/modexp_ctrl_if.sv
// Request/response bus between the modexp controller and the external Barrett multiplier.
// The controller drives the operands and a one-cycle mul_en; the multiplier answers with a one-cycle mul_valid.
interface modexp_ctrl_if #(
    parameter int W = 256
);
    logic         mul_en;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic [W-1:0] mul_n;
    logic [W-1:0] mul_r;
    logic         mul_valid;

    modport master (
        output mul_en,
        output mul_a,
        output mul_b,
        output mul_n,
        input  mul_r,
        input  mul_valid
    );

    modport slave (
        input  mul_en,
        input  mul_a,
        input  mul_b,
        input  mul_n,
        output mul_r,
        output mul_valid
    );
endinterface

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer: result = base^exp mod n.
// Every modular product is delegated to an external multiplier through the mul interface.
module modexp_ctrl #(
    parameter int W    = 256,
    parameter int EXPW = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [W-1:0]    base,
    input  logic [EXPW-1:0] exp,
    input  logic [W-1:0]    n,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [W-1:0]    result,
    modexp_ctrl_if.master   mul
);

    localparam int IDXW = (EXPW > 1) ? $clog2(EXPW) : 1;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        WAIT_L,
        SCAN,
        SQR,
        WAIT_S,
        MUL,
        WAIT_M,
        NXT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [EXPW-1:0] exp_q;
    logic [W-1:0]    n_q;
    logic [W-1:0]    base_red;
    logic [W-1:0]    r_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [IDXW-1:0] idx;
    logic            err_flag;
    logic            cur_bit;
    logic            idx_zero;

    assign cur_bit  = exp_q[idx];
    assign idx_zero = (idx == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = (n == '0) ? DONE : LOAD;
            LOAD:   state_next = WAIT_L;
            WAIT_L: if (mul.mul_valid) state_next = SCAN;
            SCAN: begin
                if (cur_bit) begin
                    state_next = idx_zero ? DONE : SQR;
                end else if (idx_zero) begin
                    state_next = DONE;
                end
            end
            SQR:    state_next = WAIT_S;
            WAIT_S: if (mul.mul_valid) state_next = cur_bit ? MUL : NXT;
            MUL:    state_next = WAIT_M;
            WAIT_M: if (mul.mul_valid) state_next = NXT;
            NXT:    state_next = idx_zero ? DONE : SQR;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mul.mul_en = 1'b0;
        busy       = (state != IDLE);
        case (state)
            LOAD, SQR, MUL: mul.mul_en = 1'b1;
            default:        mul.mul_en = 1'b0;
        endcase
    end

    assign mul.mul_a = a_q;
    assign mul.mul_b = b_q;
    assign mul.mul_n = n_q;

    // Operands are registered on the transition into an issue state, so they stay
    // frozen from the mul_en cycle until the matching mul_valid is consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q    <= '0;
            n_q      <= '0;
            base_red <= '0;
            r_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            idx      <= '0;
            err_flag <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q    <= exp;
                        n_q      <= n;
                        err_flag <= (n == '0);
                        r_q      <= '0;
                        a_q      <= base;
                        b_q      <= W'(1);
                    end
                end
                WAIT_L: begin
                    if (mul.mul_valid) begin
                        base_red <= mul.mul_r;
                        idx      <= IDXW'(EXPW - 1);
                    end
                end
                SCAN: begin
                    if (cur_bit) begin
                        r_q <= base_red;
                        if (!idx_zero) begin
                            idx <= idx - 1'b1;
                            a_q <= base_red;
                            b_q <= base_red;
                        end
                    end else if (idx_zero) begin
                        // exp == 0: the answer is 1 mod n, which collapses to 0 for n == 1
                        r_q <= W'(n_q != W'(1));
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                WAIT_S: begin
                    if (mul.mul_valid) begin
                        r_q <= mul.mul_r;
                        if (cur_bit) begin
                            a_q <= mul.mul_r;
                            b_q <= base_red;
                        end
                    end
                end
                WAIT_M: begin
                    if (mul.mul_valid) begin
                        r_q <= mul.mul_r;
                    end
                end
                NXT: begin
                    if (!idx_zero) begin
                        idx <= idx - 1'b1;
                        a_q <= r_q;
                        b_q <= r_q;
                    end
                end
                DONE: begin
                    result <= r_q;
                    done   <= 1'b1;
                    err    <= err_flag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Scoreboard bench for modexp_ctrl with a behavioural multiplier of configurable latency.
module tb_modexp_ctrl;

    localparam int W    = 32;
    localparam int EXPW = 16;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            start = 1'b0;
    logic [W-1:0]    base  = '0;
    logic [EXPW-1:0] exp   = '0;
    logic [W-1:0]    n     = '0;
    logic            busy;
    logic            done;
    logic            err;
    logic [W-1:0]    result;

    modexp_ctrl_if #(.W(W)) mb ();

    modexp_ctrl #(.W(W), .EXPW(EXPW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .base   (base),
        .exp    (exp),
        .n      (n),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result),
        .mul    (mb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         e;
    } expect_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    expect_t      sb_q[$];
    op_t          op_q[$];
    int           tests      = 0;
    int           fails      = 0;
    int           mul_count  = 0;
    int           done_count = 0;
    int           lat_fixed  = 1;
    bit           lat_random = 1'b0;
    bit           spur_arm   = 1'b0;
    bit           spur_pend  = 1'b0;
    bit           mul_active = 1'b0;
    logic [W-1:0] cur_n      = '0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        tests++;
        if (actual !== required) begin
            fails++;
            $display("[TB] FAIL %s: actual %0d required %0d", name, actual, required);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest queued expectation.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_done", {63'b0, done}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("result", result, e.res);
                    checkOutput("err", err, e.e);
                end
            end
        end
    end

    // Behavioural multiplier: answers after lat cycles, checks operand stability meanwhile.
    initial begin
        logic [W-1:0]    a, b, nn;
        logic [63:0]     prod;
        int              lat;
        bit              stable, aborted;
        op_t             o;
        mb.mul_valid = 1'b0;
        mb.mul_r     = '0;
        forever begin
            @(negedge clk);
            mb.mul_valid = 1'b0;
            if (spur_pend) begin
                mb.mul_valid = 1'b1;
                mb.mul_r     = 32'hDEAD_BEEF;
                spur_pend    = 1'b0;
            end
            if (mb.mul_en === 1'b1) begin
                a = mb.mul_a;
                b = mb.mul_b;
                nn = mb.mul_n;
                mul_count++;
                mul_active = 1'b1;
                stable = 1'b1;
                aborted = 1'b0;
                checkOutput("mul_n", nn, cur_n);
                if (op_q.size() > 0) begin
                    o = op_q.pop_front();
                    checkOutput("mul_op_ab", {a, b}, {o.a, o.b});
                end
                lat = lat_random ? int'($urandom_range(1, 20)) : lat_fixed;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (rst === 1'b0) aborted = 1'b1;
                    else if (!aborted && (mb.mul_a !== a || mb.mul_b !== b || mb.mul_n !== nn)) stable = 1'b0;
                end
                if (!aborted) checkOutput("operand_stable", {63'b0, stable}, 64'd1);
                prod = 64'(a) * 64'(b);
                mb.mul_r     = (nn == '0) ? '0 : W'(prod % 64'(nn));
                mb.mul_valid = 1'b1;
                if (spur_arm) begin
                    spur_pend = 1'b1;
                    spur_arm  = 1'b0;
                end
                mul_active = 1'b0;
            end
        end
    end

    task automatic startOp(input logic [W-1:0] b, input logic [EXPW-1:0] e, input logic [W-1:0] nv);
        @(posedge clk);
        #1;
        base  = b;
        exp   = e;
        n     = nv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        bit got;
        got = 1'b0;
        cycles = 0;
        while (!got && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) checkOutput("busy_after_start", {63'b0, busy}, 64'd1);
            if (done === 1'b1) got = 1'b1;
        end
        checkOutput("done_seen", {63'b0, got}, 64'd1);
    endtask

    task automatic applyStimulus(input logic [W-1:0] b, input logic [EXPW-1:0] e, input logic [W-1:0] nv,
                                 input logic [W-1:0] exp_res, input logic exp_err, input int exp_muls,
                                 input int exp_cycles);
        int cycles;
        sb_q.push_back('{res: exp_res, e: exp_err});
        cur_n = nv;
        mul_count = 0;
        startOp(b, e, nv);
        waitDone(cycles);
        if (exp_cycles > 0) checkOutput("done_latency", cycles, exp_cycles);
        repeat (3) @(negedge clk);
        checkOutput("mul_count", mul_count, exp_muls);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles, dc, guard;

        #2 rst = 1'b0;
        #1;
        checkOutput("rst_busy", {63'b0, busy}, 64'd0);
        checkOutput("rst_done", {63'b0, done}, 64'd0);
        checkOutput("rst_err", {63'b0, err}, 64'd0);
        checkOutput("rst_mul_en", {63'b0, mb.mul_en}, 64'd0);
        checkOutput("rst_result", result, 64'd0);
        checkOutput("rst_mul_ab", {mb.mul_a, mb.mul_b}, 64'd0);
        checkOutput("rst_mul_n", mb.mul_n, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 4^13 mod 497: B=4, R: 4 ->16 ->64 ->120 ->484 ->445
        op_q.push_back('{a: 4,   b: 1});
        op_q.push_back('{a: 4,   b: 4});
        op_q.push_back('{a: 16,  b: 4});
        op_q.push_back('{a: 64,  b: 64});
        op_q.push_back('{a: 120, b: 120});
        op_q.push_back('{a: 484, b: 4});
        lat_fixed = 1;
        applyStimulus(4, 13, 497, 445, 1'b0, 6, -1);
        checkOutput("op_queue_drained", op_q.size(), 0);

        lat_random = 1'b1;
        applyStimulus(10, 3, 7, 6, 1'b0, 3, -1);
        applyStimulus(12, 7, 13, 12, 1'b0, 5, -1);
        lat_random = 1'b0;

        applyStimulus(5, 0, 7, 1, 1'b0, 1, -1);
        applyStimulus(5, 0, 1, 0, 1'b0, 1, -1);
        applyStimulus(9, 6, 0, 0, 1'b1, 0, 2);
        applyStimulus(2, 1, 11, 2, 1'b0, 1, -1);

        // start during busy plus a stray mul_valid while scanning
        sb_q.push_back('{res: 6, e: 1'b0});
        cur_n = 7;
        mul_count = 0;
        dc = done_count;
        spur_arm = 1'b1;
        startOp(10, 3, 7);
        repeat (2) @(posedge clk);
        startOp(2, 5, 11);
        waitDone(cycles);
        repeat (40) @(negedge clk);
        checkOutput("busy_mul_count", mul_count, 3);
        checkOutput("busy_done_count", done_count - dc, 1);

        // asynchronous reset while waiting on a square
        lat_fixed = 5;
        cur_n = 497;
        mul_count = 0;
        startOp(4, 13, 497);
        guard = 0;
        while (mul_count < 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reached_wait_s", {63'b0, (mul_count >= 2)}, 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_busy", {63'b0, busy}, 64'd0);
        checkOutput("mid_rst_done_err", {62'b0, done, err}, 64'd0);
        checkOutput("mid_rst_mul_en", {63'b0, mb.mul_en}, 64'd0);
        checkOutput("mid_rst_result", result, 64'd0);
        checkOutput("mid_rst_mul_abn", {mb.mul_a | mb.mul_n, mb.mul_b}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        guard = 0;
        while (mul_active && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("late_valid_delivered", {63'b0, mul_active}, 64'd0);
        repeat (3) @(negedge clk);
        lat_fixed = 1;
        applyStimulus(3, 5, 11, 1, 1'b0, 4, -1);

        checkOutput("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
